pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and bubble counters.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; all state elements clear on reset_n low, independent of clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 id_src_A, id_src_B  in  3 each  ID-stage source registers.
REQ-006 id_uses_A, id_uses_B  in  1 each  ID instruction actually reads that source.
REQ-007 ex_is_load  in  1  EX holds LDR/LDB/LDI; ex_dest  in  3  its destination.
REQ-008 imem_read, imem_resp  in  1 each  fetch request and response.
REQ-009 dmem_req, dmem_resp  in  1 each  MEM-stage data access and response.
REQ-010 mem_indirect  in  1  MEM holds LDI/STI, which needs two data accesses.
REQ-011 br_taken  in  1  MEM resolved a taken branch/JMP/JSR/TRAP.
REQ-012 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage register enables.
REQ-013 bubble_id_ex  out  1  load a NOP control word into ID/EX.
REQ-014 flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  squash that stage register.
REQ-015 indirect_phase  out  1  0 = pointer access, 1 = data access of LDI/STI.
REQ-016 stall_cnt, bubble_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-017 SHALL implement the FSM states RUN, IND2; reset state is RUN.
REQ-018 mem_stall SHALL equal (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp) | (state==RUN & mem_indirect & dmem_resp).
REQ-019 RUN -> IND2 when mem_indirect & dmem_resp; IND2 -> RUN when dmem_resp & ~(imem_read & ~imem_resp); otherwise the state holds.
REQ-020 indirect_phase SHALL be 1 only in IND2.
REQ-021 While mem_stall is high, every load_* SHALL be 0 and every flush/bubble output SHALL be 0; this condition has top priority.
REQ-022 Without mem_stall and with br_taken: all load_* SHALL be 1 and flush_if_id, flush_id_ex, flush_ex_mem SHALL each be 1 for exactly that cycle; the load-use check is suppressed.
REQ-023 load_use SHALL equal ex_is_load & ((id_uses_A & id_src_A==ex_dest) | (id_uses_B & id_src_B==ex_dest)).
REQ-024 Without mem_stall or br_taken, with load_use: load_pc=0, load_if_id=0, load_id_ex=1, bubble_id_ex=1, load_ex_mem=1, load_mem_wb=1; exactly one bubble per load, since the load leaves EX next cycle.
REQ-025 Otherwise all load_* SHALL be 1 and all flush/bubble outputs SHALL be 0.
REQ-026 Outputs SHALL be combinational from state and inputs; there is zero-cycle latency from input to enable.
REQ-027 stall_cnt SHALL increment on every clk edge where mem_stall=1, saturating at all-ones.
REQ-028 bubble_cnt SHALL increment when bubble_id_ex=1, saturating at all-ones.
REQ-029 If br_taken and IND2 coincide, the flush SHALL take effect only on the cycle the pipeline advances.
REQ-030 If imem and dmem both stall, the block SHALL hold until both responses are seen; responses are level signals, sampled each cycle.

Reset
REQ-031 While reset_n=0: state=RUN, stall_cnt=0, bubble_cnt=0, indirect_phase=0.
REQ-032 If reset_n is asserted mid-IND2, the state SHALL return to RUN immediately, and the partial indirect access is abandoned.
REQ-033 After reset release with all inputs low: all load_*=1 and all flush/bubble outputs=0.

Verification
REQ-034 Load-use: ex_is_load=1, ex_dest=3, id_src_A=3, id_uses_A=1 -> one cycle of load_pc=0, load_if_id=0, bubble_id_ex=1; bubble_cnt goes 0->1.
REQ-035 Fetch miss: imem_read=1 and imem_resp low for 4 cycles -> all load_*=0 for 4 cycles; stall_cnt=4; resp high -> enables return to 1.
REQ-036 LDI: mem_indirect=1, dmem_resp pulses at cycles 2 and 5 -> indirect_phase goes high after the first pulse, the pipeline is frozen through the second pulse, then advances with state=RUN.
REQ-037 Branch with load-use together: br_taken=1 plus the REQ-034 hazard -> all three flushes=1, all loads=1, bubble_id_ex=0.
REQ-038 Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt holds at 15.
REQ-039 Reset in IND2: reset_n driven low asynchronously -> state=RUN, counters=0, indirect_phase=0 without waiting for a clk edge.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: derives stage enables, bubbles
// and flushes from memory handshakes, load-use hazards and taken branches.
module pipeline_stall_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       id_src_A,
  input  logic [2:0]       id_src_B,
  input  logic             id_uses_A,
  input  logic             id_uses_B,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             mem_indirect,
  input  logic             br_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             indirect_phase,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [0:0] {StRun, StInd2} state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic       w_fetch_wait;
  logic       w_data_wait;
  logic       w_ptr_done;
  logic       w_mem_stall;
  logic       w_load_use;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_fetch_wait = imem_read & ~imem_resp;
  assign w_data_wait  = dmem_req & ~dmem_resp;
  // Pointer half of LDI/STI completed: hold MEM so the data access can follow.
  assign w_ptr_done   = (r_state == StRun) & mem_indirect & dmem_resp;
  assign w_mem_stall  = w_fetch_wait | w_data_wait | w_ptr_done;

  assign w_load_use = ex_is_load & ((id_uses_A & (id_src_A == ex_dest)) |
                                    (id_uses_B & (id_src_B == ex_dest)));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StRun:   if (mem_indirect & dmem_resp) w_state_nxt = StInd2;
      StInd2:  if (dmem_resp & ~w_fetch_wait) w_state_nxt = StRun;
      default: w_state_nxt = StRun;
    endcase
  end

  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (w_mem_stall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (br_taken) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (w_load_use) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
    end
  end

  assign indirect_phase = (r_state == StInd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StRun;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_mem_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bubble_id_ex && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed hazard scenarios plus random traffic,
// checked against a behavioural model on a 16-bit and a 4-bit counter instance.
module tb_pipeline_stall_ctrl;

  typedef struct packed {
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       uses_a;
    logic       uses_b;
    logic       ex_is_load;
    logic [2:0] ex_dest;
    logic       imem_read;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;
    logic       mem_indirect;
    logic       br_taken;
  } stim_t;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [15:0] s16;
    logic [15:0] b16;
    logic [3:0]  s4;
    logic [3:0]  b4;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] id_src_A = '0, id_src_B = '0, ex_dest = '0;
  logic id_uses_A = 0, id_uses_B = 0, ex_is_load = 0, imem_read = 0, imem_resp = 0;
  logic dmem_req = 0, dmem_resp = 0, mem_indirect = 0, br_taken = 0;

  logic l_pc16, l_ifid16, l_idex16, l_exmem16, l_memwb16, bub16, f_ifid16, f_idex16, f_exmem16;
  logic ind16;
  logic l_pc4, l_ifid4, l_idex4, l_exmem4, l_memwb4, bub4, f_ifid4, f_idex4, f_exmem4, ind4;
  logic [15:0] stall16, bcnt16;
  logic [3:0]  stall4, bcnt4;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .id_src_A(id_src_A), .id_src_B(id_src_B),
    .id_uses_A(id_uses_A), .id_uses_B(id_uses_B), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .mem_indirect(mem_indirect), .br_taken(br_taken), .load_pc(l_pc16), .load_if_id(l_ifid16),
    .load_id_ex(l_idex16), .load_ex_mem(l_exmem16), .load_mem_wb(l_memwb16),
    .bubble_id_ex(bub16), .flush_if_id(f_ifid16), .flush_id_ex(f_idex16),
    .flush_ex_mem(f_exmem16), .indirect_phase(ind16), .stall_cnt(stall16), .bubble_cnt(bcnt16)
  );

  pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .id_src_A(id_src_A), .id_src_B(id_src_B),
    .id_uses_A(id_uses_A), .id_uses_B(id_uses_B), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .mem_indirect(mem_indirect), .br_taken(br_taken), .load_pc(l_pc4), .load_if_id(l_ifid4),
    .load_id_ex(l_idex4), .load_ex_mem(l_exmem4), .load_mem_wb(l_memwb4),
    .bubble_id_ex(bub4), .flush_if_id(f_ifid4), .flush_id_ex(f_idex4),
    .flush_ex_mem(f_exmem4), .indirect_phase(ind4), .stall_cnt(stall4), .bubble_cnt(bcnt4)
  );

  int n_checks = 0;
  int n_pass = 0;
  exp_t exp_q[$];

  // Reference model state
  bit m_ind2 = 0;
  int m_s16 = 0, m_b16 = 0, m_s4 = 0, m_b4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic step(input stim_t s);
    bit fetch_wait, data_wait, first_ptr, frozen, hazard, bub;
    logic [4:0] loads;
    logic [2:0] flush;
    exp_t e;
    @(negedge clk);
    id_src_A = s.src_a; id_src_B = s.src_b; id_uses_A = s.uses_a; id_uses_B = s.uses_b;
    ex_is_load = s.ex_is_load; ex_dest = s.ex_dest; imem_read = s.imem_read;
    imem_resp = s.imem_resp; dmem_req = s.dmem_req; dmem_resp = s.dmem_resp;
    mem_indirect = s.mem_indirect; br_taken = s.br_taken;
    #1;
    fetch_wait = s.imem_read && !s.imem_resp;
    data_wait  = s.dmem_req && !s.dmem_resp;
    first_ptr  = !m_ind2 && s.mem_indirect && s.dmem_resp;
    frozen     = fetch_wait || data_wait || first_ptr;
    hazard = s.ex_is_load && ((s.uses_a && s.src_a == s.ex_dest) ||
                              (s.uses_b && s.src_b == s.ex_dest));
    loads = 5'b00000; flush = 3'b000; bub = 0;
    if (!frozen) begin
      if (s.br_taken) begin
        loads = 5'b11111; flush = 3'b111;
      end else if (hazard) begin
        loads = 5'b00111; bub = 1;
      end else begin
        loads = 5'b11111;
      end
    end
    e.ctrl = {loads, bub, flush, m_ind2};
    e.s16 = 16'(m_s16); e.b16 = 16'(m_b16); e.s4 = 4'(m_s4); e.b4 = 4'(m_b4);
    exp_q.push_back(e);
    if (frozen) begin m_s16 = sat_inc(m_s16, 65535); m_s4 = sat_inc(m_s4, 15); end
    if (bub) begin m_b16 = sat_inc(m_b16, 65535); m_b4 = sat_inc(m_b4, 15); end
    if (!m_ind2) m_ind2 = s.mem_indirect && s.dmem_resp;
    else m_ind2 = !(s.dmem_resp && !fetch_wait);
  endtask

  // Monitor: the DUT presents a decision every cycle; compare it to the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl16", {l_pc16, l_ifid16, l_idex16, l_exmem16, l_memwb16, bub16, f_ifid16,
                       f_idex16, f_exmem16, ind16}, e.ctrl);
        chk("ctrl4", {l_pc4, l_ifid4, l_idex4, l_exmem4, l_memwb4, bub4, f_ifid4,
                      f_idex4, f_exmem4, ind4}, e.ctrl);
        chk("stall_cnt16", stall16, e.s16);
        chk("bubble_cnt16", bcnt16, e.b16);
        chk("stall_cnt4", stall4, e.s4);
        chk("bubble_cnt4", bcnt4, e.b4);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cnt;
    #3;
    chk("reset_ind", ind16, 1'b0);
    chk("reset_stall", stall16, 16'd0);
    chk("reset_bubble", bcnt16, 16'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    step('0);
    // Load-use hazard, then the load has left EX
    s = '0; s.ex_is_load = 1; s.ex_dest = 3'd3; s.src_a = 3'd3; s.uses_a = 1;
    step(s);
    step('0);
    // Fetch miss for four cycles
    s = '0; s.imem_read = 1;
    repeat (4) step(s);
    s.imem_resp = 1;
    step(s);
    // LDI: pointer access completes, then the data access
    s = '0; s.mem_indirect = 1; s.dmem_req = 1;
    step(s);
    s.dmem_resp = 1; step(s);
    s.dmem_resp = 0; step(s); step(s);
    s.dmem_resp = 1; step(s);
    step('0);
    // Branch coincides with the load-use hazard
    s = '0; s.ex_is_load = 1; s.ex_dest = 3'd3; s.src_a = 3'd3; s.uses_a = 1; s.br_taken = 1;
    step(s);
    // Branch while in IND2 with data still outstanding, then when it advances
    s = '0; s.mem_indirect = 1; s.dmem_req = 1; s.dmem_resp = 1; step(s);
    s.dmem_resp = 0; s.br_taken = 1; step(s);
    s.dmem_resp = 1; step(s);
    // Both memories stall; the data response alone must not release the pipeline
    s = '0; s.imem_read = 1; s.dmem_req = 1; step(s);
    s.dmem_resp = 1; step(s);
    s.imem_resp = 1; step(s);
    // 20 stalls saturate the 4-bit counter
    s = '0; s.imem_read = 1;
    repeat (20) step(s);
    step('0);
    chk("stall4_saturated", stall4, 4'd15);

    for (int i = 0; i < 2000; i++) begin
      s.src_a = 3'($urandom_range(0, 7));
      s.src_b = 3'($urandom_range(0, 7));
      s.ex_dest = ($urandom_range(0, 1) != 0) ? s.src_a : 3'($urandom_range(0, 7));
      s.uses_a = 1'($urandom_range(0, 1));
      s.uses_b = 1'($urandom_range(0, 1));
      s.ex_is_load = 1'($urandom_range(0, 1));
      s.imem_read = 1'($urandom_range(0, 1));
      s.imem_resp = ($urandom_range(0, 3) != 0);
      s.dmem_req = 1'($urandom_range(0, 1));
      s.dmem_resp = ($urandom_range(0, 2) != 0);
      s.mem_indirect = ($urandom_range(0, 3) == 0);
      s.br_taken = ($urandom_range(0, 5) == 0);
      step(s);
    end

    // Asynchronous reset while in IND2
    s = '0; s.mem_indirect = 1; s.dmem_req = 1; s.dmem_resp = 1;
    step(s);
    s.dmem_resp = 0; step(s);
    step(s);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ind", ind16, 1'b0);
    chk("async_rst_stall", stall16, 16'd0);
    chk("async_rst_bubble", bcnt16, 16'd0);
    chk("async_rst_stall4", stall4, 4'd0);
    m_ind2 = 0; m_s16 = 0; m_b16 = 0; m_s4 = 0; m_b4 = 0;
    id_src_A = '0; id_src_B = '0; id_uses_A = 0; id_uses_B = 0; ex_is_load = 0; ex_dest = '0;
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0; mem_indirect = 0; br_taken = 0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    step('0);
    s = '0; s.ex_is_load = 1; s.ex_dest = 3'd5; s.src_b = 3'd5; s.uses_b = 1;
    step(s);
    step('0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
